// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus port between NUM_INPUTS requesters.
// Grants are held until last, withdrawal or watchdog expiry; priority rotates after each grant.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | no grant open, scanning from ptr for the next valid requester
// BUSY  | grant_idx owns the shared bus until last, withdrawal or watchdog expiry
module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS     = 3,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IDX_W         = $clog2(NUM_INPUTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
   output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
   output cbus_req_t                    oreq,
   input  cbus_resp_t                   oresp,
   output logic                         busy,
   output logic [IDX_W-1:0]             grant_idx,
   output logic                         timeout
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
   localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(NUM_INPUTS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_n;
   logic [IDX_W-1:0]  ptr;
   logic [WD_W-1:0]   wd;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_found;
   logic [IDX_W:0]    cand;
   logic [IDX_W-1:0]  next_ptr;
   logic              exit_busy;
   logic              wd_expire;

   // Scan ptr, ptr+1, ... with wrap; the sum stays below 2*NUM_INPUTS so one subtract suffices
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!sel_found && ireqs[cand[IDX_W-1:0]].valid) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign next_ptr = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

   always_comb begin
      state_n   = state;
      exit_busy = 1'b0;
      wd_expire = 1'b0;
      case (state)
         IDLE: if (sel_found) state_n = BUSY;
         BUSY: begin
            if (oresp.last) begin
               exit_busy = 1'b1;
            end else if (!ireqs[grant_idx].valid) begin
               exit_busy = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && wd == WD_LAST) begin
               exit_busy = 1'b1;
               wd_expire = 1'b1;
            end
            if (exit_busy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      oreq   = '0;
      iresps = '0;
      if (state == BUSY) begin
         oreq              = ireqs[grant_idx];
         iresps[grant_idx] = oresp;
      end
   end

   assign busy = (state == BUSY);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         grant_idx <= '0;
         ptr       <= '0;
         wd        <= '0;
         timeout   <= 1'b0;
      end else begin
         state   <= state_n;
         timeout <= wd_expire;
         if (state == IDLE && sel_found) begin
            grant_idx <= sel_idx;
            wd        <= '0;
         end else if (state == BUSY) begin
            wd <= wd + 1'b1;
         end
         if (exit_busy) ptr <= next_ptr;
      end
   end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: cycle vector table plus reset and watchdog sequences.
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   logic                 clk;
   logic                 reset;
   cbus_req_t  [2:0]     ireqs;
   cbus_resp_t [2:0]     iresps;
   cbus_req_t            oreq;
   cbus_resp_t           oresp;
   logic                 busy;
   logic [1:0]           grant_idx;
   logic                 timeout;

   int tests  = 0;
   int errors = 0;

   cbus_rr_arbiter #(.NUM_INPUTS(3), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
      .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  vm;
      logic        last;
      logic [31:0] data;
      logic        exp_busy;
      logic [1:0]  exp_g;
      logic        exp_to;
   } row_t;

   row_t rows[$];

   function automatic cbus_req_t req_of(int i, logic [2:0] vm);
      cbus_req_t r;
      r.valid = vm[i];
      r.we    = (i % 2) == 1;
      r.addr  = 32'h100 * (i + 1);
      r.wdata = 32'hA000 + i;
      return r;
   endfunction

   task automatic drive(logic [2:0] vm, logic last, logic [31:0] data);
      for (int i = 0; i < 3; i++) ireqs[i] = req_of(i, vm);
      oresp.ready = 1'b1;
      oresp.last  = last;
      oresp.data  = data;
   endtask

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full-state check of the current cycle against expected busy/grant/timeout and current inputs
   task automatic check_cycle(string tag, logic [2:0] vm, logic eb, logic [1:0] eg, logic et);
      cbus_req_t        e_req;
      cbus_resp_t [2:0] e_resp;
      e_req  = '0;
      e_resp = '0;
      if (eb) begin
         e_req      = req_of(int'(eg), vm);
         e_resp[eg] = oresp;
      end
      check({tag, ".busy"},    128'(busy),      128'(eb));
      check({tag, ".grant"},   128'(grant_idx), 128'(eg));
      check({tag, ".timeout"}, 128'(timeout),   128'(et));
      check({tag, ".oreq"},    128'(oreq),      128'(e_req));
      check({tag, ".iresps"},  128'(iresps),    128'(e_resp));
   endtask

   function automatic void add(logic [2:0] vm, logic last, logic [31:0] data,
                               logic eb, logic [1:0] eg, logic et);
      row_t r;
      r.vm = vm; r.last = last; r.data = data;
      r.exp_busy = eb; r.exp_g = eg; r.exp_to = et;
      rows.push_back(r);
   endfunction

   initial begin
      // rotation 0,1,2,0,1 with last two cycles after each grant
      add(3'd7, 0, 32'h1000, 0, 2'd0, 0);
      add(3'd7, 0, 32'h1001, 1, 2'd0, 0);
      add(3'd7, 1, 32'h1002, 1, 2'd0, 0);
      add(3'd7, 0, 32'h1003, 0, 2'd0, 0);
      add(3'd7, 0, 32'h1004, 1, 2'd1, 0);
      add(3'd7, 1, 32'h1005, 1, 2'd1, 0);
      add(3'd7, 0, 32'h1006, 0, 2'd1, 0);
      add(3'd7, 0, 32'h1007, 1, 2'd2, 0);
      add(3'd7, 1, 32'h1008, 1, 2'd2, 0);
      add(3'd7, 0, 32'h1009, 0, 2'd2, 0);
      add(3'd7, 0, 32'h100A, 1, 2'd0, 0);
      add(3'd7, 1, 32'h100B, 1, 2'd0, 0);
      add(3'd7, 0, 32'h100C, 0, 2'd0, 0);
      add(3'd7, 0, 32'h100D, 1, 2'd1, 0);
      add(3'd7, 1, 32'h100E, 1, 2'd1, 0);
      // wrap/skip from ptr=2
      add(3'd2, 0, 32'h100F, 0, 2'd1, 0);
      add(3'd2, 1, 32'h1010, 1, 2'd1, 0);
      add(3'd5, 0, 32'h1011, 0, 2'd1, 0);
      add(3'd5, 1, 32'h1012, 1, 2'd2, 0);
      add(3'd5, 0, 32'h1013, 0, 2'd2, 0);
      add(3'd5, 1, 32'h1014, 1, 2'd0, 0);
      // routing isolation on grant 1
      add(3'd2, 0, 32'h1015, 0, 2'd0, 0);
      add(3'd2, 0, 32'hDEAD, 1, 2'd1, 0);
      add(3'd2, 1, 32'h1017, 1, 2'd1, 0);
      // withdrawal of grant 2, then ptr=0 gives input 0 priority over 1
      add(3'd4, 0, 32'h1018, 0, 2'd1, 0);
      add(3'd4, 0, 32'h1019, 1, 2'd2, 0);
      add(3'd0, 0, 32'h101A, 1, 2'd2, 0);
      add(3'd3, 0, 32'h101B, 0, 2'd2, 0);
      add(3'd3, 1, 32'h101C, 1, 2'd0, 0);
      add(3'd0, 0, 32'h101D, 0, 2'd0, 0);

      // reset held two cycles with all inputs valid
      reset = 1'b0;
      drive(3'd7, 0, 32'h0);
      @(negedge clk);
      check_cycle("rst0", 3'd7, 0, 2'd0, 0);
      @(negedge clk);
      check_cycle("rst1", 3'd7, 0, 2'd0, 0);
      reset = 1'b1;
      @(negedge clk);
      check_cycle("first_grant", 3'd7, 1, 2'd0, 0);
      // reset mid-transaction
      reset = 1'b0;
      @(negedge clk);
      check_cycle("midrst", 3'd7, 0, 2'd0, 0);
      reset = 1'b1;

      foreach (rows[i]) begin
         drive(rows[i].vm, rows[i].last, rows[i].data);
         #1;
         check_cycle($sformatf("row%0d", i), rows[i].vm, rows[i].exp_busy, rows[i].exp_g, rows[i].exp_to);
         @(negedge clk);
      end

      // watchdog expiry: ptr=1 now, only input 0 requests, last never comes
      drive(3'd1, 0, 32'h2000);
      #1 check_cycle("wd_idle", 3'd1, 0, 2'd0, 0);
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         #1 check_cycle($sformatf("wd_busy%0d", c), 3'd1, 1, 2'd0, 0);
         @(negedge clk);
      end
      drive(3'd0, 0, 32'h2001);
      #1 check_cycle("wd_pulse", 3'd0, 0, 2'd0, 1);
      @(negedge clk);
      #1 check_cycle("wd_after", 3'd0, 0, 2'd0, 0);
      // ptr advanced to 1: input 1 beats input 0
      drive(3'd3, 0, 32'h2002);
      @(negedge clk);
      drive(3'd3, 1, 32'h2003);
      #1 check_cycle("wd_ptr", 3'd3, 1, 2'd1, 0);
      @(negedge clk);

      // last coinciding with expiry: completion, no pulse
      drive(3'd1, 0, 32'h2004);
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         drive(3'd1, c == 7, 32'h2100 + c);
         #1 check_cycle($sformatf("wdl_busy%0d", c), 3'd1, 1, 2'd0, 0);
         @(negedge clk);
      end
      drive(3'd0, 0, 32'h2005);
      #1 check_cycle("wdl_nopulse", 3'd0, 0, 2'd0, 0);
      @(negedge clk);
      #1 check_cycle("wdl_after", 3'd0, 0, 2'd0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Round-robin arbiter that shares one physical `cbus` port between `NUM_INPUTS` requesters (instruction fetch, data access, page-table walker). It holds a grant for a whole transaction (until `last`), rotates priority after each transaction so no requester starves, and runs a watchdog that aborts a granted transaction whose responder never returns `last`. It sits between the requesters and the MMU/memory side of the core bus.

## Interface

- `NUM_INPUTS`, default 3, number of requesters, must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1024, maximum cycles a grant may stay open without `last`; 0 disables the watchdog.
- `IDX_W`, default `$clog2(NUM_INPUTS)`, width of index signals (localparam).

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS-1:0]`  requester bus requests.
- `iresps`  out  `cbus_resp_t [NUM_INPUTS-1:0]`  per-requester responses.
- `oreq`  out  `cbus_req_t`  request to the shared bus.
- `oresp`  in  `cbus_resp_t`  response from the shared bus.
- `busy`  out  1  a grant is open.
- `grant_idx`  out  IDX_W  index of the current or most recent grant.
- `timeout`  out  1  one-cycle pulse when the watchdog aborts a grant.

## Operation

- State: `IDLE`, `BUSY`. Registers: `state`, `grant_idx`, round-robin pointer `ptr` (IDX_W), watchdog counter `wd` (wide enough for `TIMEOUT_CYCLES`), `timeout`.
- Selection in `IDLE` (combinational): scan `ptr, ptr+1, …, NUM_INPUTS-1, 0, …, ptr-1`. The first index with `ireqs[i].valid` wins. `ptr` wraps from `NUM_INPUTS-1` to 0.
- `IDLE` → `BUSY` when any `ireqs[i].valid`. On that edge `grant_idx` ← the selected index and `wd` ← 0. No bus traffic is driven in `IDLE`.
- In `BUSY`:
  - `oreq = ireqs[grant_idx]`, live and unregistered.
  - `iresps[grant_idx] = oresp`; every other `iresps[j]` is `'0`.
  - `wd` increments by 1 each cycle.
- `BUSY` → `IDLE` on exactly one of the following, in priority order:
  - (1) `oresp.last`: normal completion.
  - (2) `ireqs[grant_idx].valid == 0`: requester withdrew, treated as an abort and no pulse.
  - (3) `TIMEOUT_CYCLES != 0` and `wd == TIMEOUT_CYCLES-1` without `last`: `timeout` ← 1 for one cycle.
- On every `BUSY` → `IDLE` exit, `ptr` ← `grant_idx+1` mod `NUM_INPUTS`. This is the only place `ptr` changes.
- `last` coinciding with watchdog expiry counts as a completion. No `timeout` is raised.
- A new request is never granted in the same cycle as the exit; the earliest re-grant is the cycle after returning to `IDLE`.
- Reset (`reset == 0` at a rising edge), including mid-transaction, sets all of the following regardless of bus state:
  - `state` = `IDLE`
  - `grant_idx` = 0
  - `ptr` = 0
  - `wd` = 0
  - `timeout` = 0
- After reset, outputs are `oreq = '0`, `iresps = '0`, `busy = 0`, `grant_idx = 0`, `timeout = 0`.

## Timing

- Grant latency: valid seen in cycle t (in `IDLE`) → `oreq` valid in cycle t+1.
- Response path: `oresp` → `iresps[grant_idx]` is zero-latency (combinational).
- Turnaround: `last` in cycle t → `IDLE` in t+1 → next grant's `oreq` in t+2.
- `busy` equals `state == BUSY`, registered.
- `timeout` is high exactly in the cycle after the expiry edge, i.e. `TIMEOUT_CYCLES+1` cycles after the grant edge. It is then low.
- Requesters must hold `valid` and request fields stable until they see `last`.

## Test plan

- Reset/idle: hold `reset = 0` for 2 cycles with all three inputs valid, then release → `oreq = '0`, `busy = 0`, `grant_idx = 0` during reset; first grant goes to index 0 on the cycle after release.
- Rotation: N=3, all inputs valid continuously, each transaction ends with `last` 2 cycles after its grant → grants in order 0, 1, 2, 0, 1; each transaction opens 2 cycles after the previous `last`.
- Wrap/skip: `ptr = 2`, only input 1 valid → grant 1, and `ptr` becomes 2 after completion; then inputs 0 and 2 valid → grant 2 first, then 0.
- Routing isolation: grant 1, `oresp.data = 0xDEAD`, `ready = 1` → `iresps[1]` carries it; `iresps[0]` and `iresps[2]` stay all-zero.
- Watchdog: `TIMEOUT_CYCLES = 8`, grant 0, `oresp.last` never asserted → `timeout` pulses once 9 cycles after the grant edge; then idle, `ptr = 1`. Repeat with `last` at the expiry cycle → no pulse.
- Withdrawal/reset mid-op: grant 2, drop `ireqs[2].valid` → idle next cycle with no pulse and `ptr = 0`. Separately, assert `reset` mid-burst → `oreq = '0` and `busy = 0` from the next cycle.
